counter_access_arbiter: RTL and testbench
=========================================

Name: counter_access_arbiter

Overview:
- Shares one up_down_counter instance among NUM_REQ requesters.
- Each requester issues single-step increment/decrement requests over a valid/ready handshake. The block grants them round-robin and drives the counter's up/down pins with one-cycle pulses.
- It returns the post-update count to the granted requester one cycle later.
- Sits between the requesting agents and the counter; the counter's count output feeds back into this block.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 3, counter width; must match the controlled counter
- SATURATE, 0, 0 = let counter wrap; 1 = suppress steps past max/zero

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- enable  in  1  arbitration enable; low = no new grants
- req_valid  in  NUM_REQ  per-requester request pending
- req_dir  in  NUM_REQ  per-requester direction: 1 = up, 0 = down
- req_ready  out  NUM_REQ  one-hot grant; handshake completes when valid & ready
- cnt_up  out  1  up pulse to counter
- cnt_down  out  1  down pulse to counter
- cnt_value  in  WIDTH  counter's count output
- rsp_valid  out  1  response strobe, one cycle
- rsp_id  out  clog2(NUM_REQ)  index of the requester being answered
- rsp_count  out  WIDTH  count value after the granted step
- rsp_sat  out  1  step suppressed by saturation (SATURATE=1 only)

Behaviour:
- Reset values: req_ready=0, cnt_up=0, cnt_down=0, rsp_valid=0, rsp_id=0, rsp_count=0, rsp_sat=0, priority pointer=0.
- The controlled counter shares reset, so both sides start at count 0.
- Grant cycle T:
  - If enable=1 and any req_valid=1, exactly one req_ready bit is high in the same cycle. This path is combinational from req_valid, pointer and enable.
  - The winner is the first valid index at or after the pointer, searching cyclically.
- Step pulse: in cycle T, cnt_up=1 if req_dir[winner]=1, else cnt_down=1. Both pins are never high together. No pulse is issued without a grant.
- Saturation (SATURATE=1):
  - Up requested with cnt_value = 2^WIDTH-1: grant is given, no pulse, rsp_sat=1.
  - Down requested with cnt_value = 0: same handling.
  - With SATURATE=0, the counter wraps (7→0 up, 0→7 down for WIDTH=3) and rsp_sat stays 0.
- Pointer update: after a grant to index i, the pointer becomes (i+1) mod NUM_REQ at the clock edge. The pointer is unchanged when there is no grant.
- Response: rsp_valid is registered and high in T+1, with rsp_id=winner and rsp_count = cnt_value sampled in T+1 (the already-updated value).
  - rsp_sat is a registered copy of the T decision.
  - rsp_id and rsp_count hold their last values when rsp_valid=0.
- Throughput: back-to-back grants are allowed, one per cycle. A response for T and a grant for T+1 coexist in cycle T+1.
- Requester rule: after a handshake a requester may hold valid high for a further request. req_dir is sampled only in its grant cycle.
- enable deassert: blocks new grants from that cycle. A response already owed for the previous cycle still issues.
- Reset mid-operation: all outputs go to reset values immediately. Any pending response is dropped and the pointer returns to 0.
- Requesters are never stalled by a response path; there is no rsp_ready.

Decomposition:
- Package counter_arb_pkg:
  - dir encoding constants DIR_UP=1, DIR_DOWN=0
  - default WIDTH/NUM_REQ constants
  - function for cyclic next index
- Sub-module rr_arbiter: NUM_REQ-wide round-robin one-hot grant, with registered pointer and request/enable inputs. It is reusable elsewhere.
- The top level adds pulse generation, saturation check and the response register.

Test Plan:
- Reset, then req 0 valid with dir=1 for 3 handshakes:
  - cnt_up pulses in 3 consecutive cycles.
  - rsp_count = 1, 2, 3 with rsp_id=0.
  - Counter reads 3.
- All 4 requesters valid continuously, all dir=1, enable=1:
  - Grants go 0,1,2,3,0 on successive cycles.
  - rsp_id follows one cycle later.
  - rsp_count = 1..5 (mod 8).
- SATURATE=0, count=7, up request → rsp_count=0, rsp_sat=0. Then down request → rsp_count=7.
- SATURATE=1, count=0, down request:
  - Grant given, no cnt_down pulse.
  - rsp_count=0, rsp_sat=1.
  - Repeat at count=7 with up → rsp_count=7, rsp_sat=1.
- enable=0 with req 2 valid: no req_ready, no pulses for 5 cycles. Raise enable → grant to 2 in the same cycle.
- Assert reset during a cycle with rsp_valid pending:
  - rsp_valid=0 immediately, pointer=0.
  - Next grant with req 1 and req 3 valid goes to 1.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// Shared constants and helpers for the counter access arbiter.
// Exports direction encoding, default sizes and the cyclic index step.
package counter_arb_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_WIDTH   = 3;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   function automatic int next_idx(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/counter_access_arbiter_if.sv
// Requester-side bundle: per-requester request/grant and the response.
// master = requesters, slave = arbiter.
interface counter_access_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 3
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req_valid;
   logic [NUM_REQ-1:0] req_dir;
   logic [NUM_REQ-1:0] req_ready;
   logic               rsp_valid;
   logic [IDW-1:0]     rsp_id;
   logic [WIDTH-1:0]   rsp_count;
   logic               rsp_sat;

   modport master (
      output req_valid, req_dir,
      input  req_ready, rsp_valid, rsp_id, rsp_count, rsp_sat
   );

   modport slave (
      input  req_valid, req_dir,
      output req_ready, rsp_valid, rsp_id, rsp_count, rsp_sat
   );
endinterface

// File: rtl/counter_access_arbiter_rr_arbiter.sv
// Round-robin one-hot arbiter with registered priority pointer.
// Ports: clk, reset, enable, req in; grant, win_id, grant_any out.
module rr_arbiter
   import counter_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDW-1:0]     win_id,
   output logic               grant_any
);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] idx;

   // Walk cyclically from the pointer; first valid index wins.
   always_comb begin
      grant     = '0;
      win_id    = '0;
      grant_any = 1'b0;
      idx       = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_any && req[idx] && enable && !reset) begin
            grant[idx] = 1'b1;
            win_id     = idx;
            grant_any  = 1'b1;
         end
         idx = IDW'(next_idx(int'(idx), NUM_REQ));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ptr <= '0;
      else if (grant_any)
         ptr <= IDW'(next_idx(int'(win_id), NUM_REQ));
   end

endmodule

// File: rtl/counter_access_arbiter.sv
// Shares one up/down counter among NUM_REQ requesters via round robin.
// Ports: clk, reset, enable, bus (requests/response), cnt_up/down, cnt_value.
module counter_access_arbiter
   import counter_arb_pkg::*;
#(
   parameter int NUM_REQ  = DEF_NUM_REQ,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int SATURATE = 0,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   counter_access_arbiter_if.slave bus,
   output logic             cnt_up,
   output logic             cnt_down,
   input  logic [WIDTH-1:0] cnt_value
);

   logic [NUM_REQ-1:0] grant;
   logic [IDW-1:0]     win;
   logic               any;
   logic               dir;
   logic               sat;

   logic               rsp_valid_q;
   logic [IDW-1:0]     rsp_id_q;
   logic               rsp_sat_q;
   logic [WIDTH-1:0]   cnt_hold;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .req       (bus.req_valid),
      .grant     (grant),
      .win_id    (win),
      .grant_any (any)
   );

   // A suppressed step still consumes the grant; only the pulse is dropped.
   always_comb begin
      dir      = bus.req_dir[win];
      sat      = 1'b0;
      cnt_up   = 1'b0;
      cnt_down = 1'b0;
      if (any) begin
         if (SATURATE != 0)
            sat = (dir == DIR_UP) ? (cnt_value == '1)
                                  : (cnt_value == '0);
         cnt_up   = (dir == DIR_UP) && !sat;
         cnt_down = (dir != DIR_UP) && !sat;
      end
   end

   assign bus.req_ready = grant;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sat_q   <= 1'b0;
         cnt_hold    <= '0;
      end else begin
         rsp_valid_q <= any;
         if (any) begin
            rsp_id_q  <= win;
            rsp_sat_q <= sat;
         end
         if (rsp_valid_q)
            cnt_hold <= cnt_value;
      end
   end

   // In the response cycle the counter already shows the stepped value.
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sat   = rsp_sat_q;
   assign bus.rsp_count = rsp_valid_q ? cnt_value : cnt_hold;

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Bench: wrapping and saturating arbiters side by side on shared stimulus,
// each driving its own counter; scoreboard queues hold owed responses.
module tb_counter_access_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [3:0] req_valid;
   logic [3:0] req_dir;

   logic       up [2];
   logic       dn [2];
   logic [2:0] cnt [2];

   counter_access_arbiter_if #(.NUM_REQ(4), .WIDTH(3)) b0 ();
   counter_access_arbiter_if #(.NUM_REQ(4), .WIDTH(3)) b1 ();

   assign b0.req_valid = req_valid;
   assign b0.req_dir   = req_dir;
   assign b1.req_valid = req_valid;
   assign b1.req_dir   = req_dir;

   counter_access_arbiter #(.NUM_REQ(4), .WIDTH(3), .SATURATE(0)) u_dut0 (
      .clk(clk), .reset(reset), .enable(enable), .bus(b0),
      .cnt_up(up[0]), .cnt_down(dn[0]), .cnt_value(cnt[0])
   );

   counter_access_arbiter #(.NUM_REQ(4), .WIDTH(3), .SATURATE(1)) u_dut1 (
      .clk(clk), .reset(reset), .enable(enable), .bus(b1),
      .cnt_up(up[1]), .cnt_down(dn[1]), .cnt_value(cnt[1])
   );

   always #5 clk = ~clk;

   // Controlled counters: wrap on overflow, share reset with the arbiter.
   for (genvar g = 0; g < 2; g++) begin : g_cnt
      always_ff @(posedge clk or posedge reset) begin
         if (reset)      cnt[g] <= '0;
         else if (up[g]) cnt[g] <= cnt[g] + 3'd1;
         else if (dn[g]) cnt[g] <= cnt[g] - 3'd1;
      end
   end

   logic [3:0] rdy [2];
   logic       rv  [2];
   logic [1:0] rid [2];
   logic [2:0] rc  [2];
   logic       rs  [2];

   assign rdy[0] = b0.req_ready;
   assign rv[0]  = b0.rsp_valid;
   assign rid[0] = b0.rsp_id;
   assign rc[0]  = b0.rsp_count;
   assign rs[0]  = b0.rsp_sat;
   assign rdy[1] = b1.req_ready;
   assign rv[1]  = b1.rsp_valid;
   assign rid[1] = b1.rsp_id;
   assign rc[1]  = b1.rsp_count;
   assign rs[1]  = b1.rsp_sat;

   typedef struct {
      int id;
      int count;
      int sat;
   } rsp_t;

   rsp_t q0[$];
   rsp_t q1[$];
   int   mptr [2];
   int   mcnt [2];
   int   n_chk = 0;
   int   n_err = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      q0.delete();
      q1.delete();
      for (int k = 0; k < 2; k++) begin
         mptr[k] = 0;
         mcnt[k] = 0;
      end
   endtask

   task automatic check_idle(input string tag);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("%s_rdy%0d", tag, k), int'(rdy[k]), 0);
         check($sformatf("%s_up%0d", tag, k), int'(up[k]), 0);
         check($sformatf("%s_dn%0d", tag, k), int'(dn[k]), 0);
         check($sformatf("%s_rv%0d", tag, k), int'(rv[k]), 0);
         check($sformatf("%s_rid%0d", tag, k), int'(rid[k]), 0);
         check($sformatf("%s_rc%0d", tag, k), int'(rc[k]), 0);
         check($sformatf("%s_rs%0d", tag, k), int'(rs[k]), 0);
         check($sformatf("%s_cnt%0d", tag, k), int'(cnt[k]), 0);
      end
   endtask

   // Runs at the negedge: retire owed responses, then predict this cycle.
   task automatic check_cycle();
      for (int k = 0; k < 2; k++) begin
         rsp_t e;
         int   has;
         int   w;
         int   d;
         int   s;
         int   eu;
         int   ed;
         has = (k == 0) ? int'(q0.size() != 0) : int'(q1.size() != 0);
         check($sformatf("rsp_valid%0d", k), int'(rv[k]), has);
         if (has != 0) begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            if (rv[k]) begin
               check($sformatf("rsp_id%0d", k), int'(rid[k]), e.id);
               check($sformatf("rsp_count%0d", k), int'(rc[k]), e.count);
               check($sformatf("rsp_sat%0d", k), int'(rs[k]), e.sat);
            end
         end
         w = -1;
         for (int j = 0; j < 4; j++) begin
            int idx;
            idx = (mptr[k] + j) % 4;
            if (w < 0 && enable && req_valid[idx]) w = idx;
         end
         eu = 0;
         ed = 0;
         if (w >= 0) begin
            d  = int'(req_dir[w]);
            s  = (k == 1) && ((d != 0) ? (mcnt[k] == 7) : (mcnt[k] == 0));
            eu = (d != 0) && (s == 0);
            ed = (d == 0) && (s == 0);
            if (eu != 0) mcnt[k] = (mcnt[k] + 1) % 8;
            if (ed != 0) mcnt[k] = (mcnt[k] + 7) % 8;
            e.id    = w;
            e.count = mcnt[k];
            e.sat   = s;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
            mptr[k] = (w + 1) % 4;
         end
         check($sformatf("req_ready%0d", k), int'(rdy[k]),
               (w >= 0) ? (1 << w) : 0);
         check($sformatf("cnt_up%0d", k), int'(up[k]), eu);
         check($sformatf("cnt_down%0d", k), int'(dn[k]), ed);
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("reset");
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      enable    = 1'b0;
      req_valid = '0;
      req_dir   = '0;
      model_clear();
      do_reset();

      // Single requester, three increments.
      enable    = 1'b1;
      req_valid = 4'b0001;
      req_dir   = 4'b0001;
      repeat (3) cycle();
      req_valid = '0;
      cycle();
      check("count_after3", int'(cnt[0]), 3);

      // Down at zero: wrap vs saturate.
      do_reset();
      req_valid = 4'b0001;
      req_dir   = 4'b0000;
      cycle();
      req_valid = '0;
      cycle();
      check("wrap_down", int'(cnt[0]), 7);
      check("sat_down", int'(cnt[1]), 0);

      // All requesters up: rotation 0,1,2,3,0.
      do_reset();
      req_valid = 4'b1111;
      req_dir   = 4'b1111;
      repeat (5) cycle();
      req_valid = '0;
      cycle();

      // Climb to 7, step up past the top, then step down.
      req_valid = 4'b0010;
      req_dir   = 4'b0010;
      repeat (3) cycle();
      req_dir = 4'b0000;
      cycle();
      req_valid = '0;
      cycle();

      // Enable low blocks grants; raising it grants at once.
      enable    = 1'b0;
      req_valid = 4'b0100;
      req_dir   = 4'b0100;
      repeat (5) cycle();
      enable = 1'b1;
      cycle();
      req_valid = '0;
      cycle();

      // Reset while a response is owed.
      req_valid = 4'b0001;
      req_dir   = 4'b0001;
      cycle();
      req_valid = '0;
      check("pre_reset_rv", int'(rv[0]), 1);
      reset = 1'b1;
      #1;
      check_idle("midreset");
      model_clear();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 4'b1010;
      req_dir   = 4'b1010;
      cycle();
      req_valid = '0;
      cycle();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
